video_effects_stream: RTL and testbench
=======================================

# video_effects_stream

Streaming, parametrised pixel-effects engine sitting between the video DMA Avalon-ST source and the video output sink in the Nios video pipeline. It applies any combination of five effects: colour delete, colour substitute, quantisation, grayscale and negative. Effects are chained in a fixed order through a two-stage pipeline with full valid/ready backpressure. Effect selection and colour operands are latched per frame at start-of-packet, so register writes never tear a frame.

## Interface
- R_BITS, 5, red channel width (4..8)
- G_BITS, 6, green channel width (4..8)
- B_BITS, 5, blue channel width (4..8)
- QUANT_DROP, 2, LSBs cleared per channel by quantisation (1..3)
- PW (derived), R_BITS+G_BITS+B_BITS, pixel width; layout {R,G,B}, R in MSBs
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- effect  in  5  enable mask: [0] delete, [1] substitute, [2] quantise, [3] grayscale, [4] negative
- effect_delete_mask  in  PW  bits to clear when delete is enabled
- effect_key_color  in  PW  match value for substitute
- effect_substitute_color  in  PW  replacement value for substitute
- in_data  in  PW  sink pixel
- in_valid  in  1  sink valid
- in_ready  out  1  sink ready
- in_sop / in_eop  in  1 each  start/end of frame
- out_data  out  PW  source pixel
- out_valid  out  1  source valid
- out_ready  in  1  downstream ready
- out_sop / out_eop  out  1 each  frame markers, delayed with their pixel
- frame_active  out  1  high from accepted sop beat to accepted eop beat at output

## Operation
- Beat accepted on input when in_valid && in_ready. Beat leaves when out_valid && out_ready.
- Config latch: on an accepted beat with in_sop=1, capture effect, mask, key and substitute colour into cfg registers. That beat and all later beats use them. Beats before the first sop use cfg at reset value: effect=0, i.e. bypass.
- Each pipeline stage carries its own copy of the cfg effect bits alongside data, sop and eop. Frames in flight keep their settings.
- Stage 1, applied in order:
  - delete: p &= ~mask
  - substitute: if p == key, then p = subst. Compare happens after delete.
  - quantise: clear the QUANT_DROP LSBs of each channel.
- Stage 2, applied in order:
  - grayscale:
    - Expand each channel to 8 bits by MSB replication: c8 = (c << (8-W)) | (c >> (2W-8)).
    - Y = (77·R8 + 150·G8 + 29·B8) >> 8. Use an 16-bit unsigned accumulator; no rounding.
    - Repack: R = Y>>(8-R_BITS), G = Y>>(8-G_BITS), B = Y>>(8-B_BITS).
  - negative: p = ~p.
- A disabled effect passes the pixel through unchanged. effect=0 is pure delay.
- frame_active sets on output sop acceptance and clears on output eop acceptance. If sop and eop are on the same beat, it stays 0.

## Timing
- Latency: 2 cycles from input acceptance to out_valid, with out_ready held high.
- Throughput: 1 pixel/cycle sustained.
- Stage k loads when it is empty or when its content advances in the same cycle.
- in_ready = !s1_valid || !s2_valid || out_ready. in_ready is combinational from out_ready; no other combinational paths from input to output.
- While out_valid && !out_ready, out_data/sop/eop stay stable. No beat is dropped or duplicated.
- Pipeline holds at most 2 beats. In_ready goes low exactly when both stages are full and out_ready=0.
- Reset values (asynchronous assert): all valids 0, out_data 0, out_sop/out_eop 0, frame_active 0, all cfg registers 0.
- Reset deasserts synchronously to clk at the first rising edge with reset=1. Pixels in flight when reset asserts are discarded.
- A sop arriving while the previous frame is still in the pipeline is legal. The previous frame's beats keep the old cfg.
- Register-port changes without a sop have no effect until the next accepted sop.

## Test plan
- Bypass: effect=0, stream 0x1234, 0xF800, 0x07E0 with out_ready=1 -> identical values out, each 2 cycles after input.
- Negative and grayscale: effect=10000 sop pixel 0xF800 -> 0x07FF. Effect=01000 sop pixels 0xF800 and 0xFFFF -> 0x4A69 and 0xFFFF.
- Chain: effect=00111 (delete + substitute + quantise), mask=0x001F, key=0xF800, subst=0x0000, pixels 0xF81F and 0xFFFF -> 0x0000 and 0xE780.
- Backpressure: random out_ready with 30% low over a 1000-beat frame -> output sequence equals the model. In_ready low only when 2 beats are held; stable data during stalls.
- Per-frame latch: change effect from 00000 to 10000 mid-frame -> the remaining beats of that frame are unchanged; the next frame from its sop onward is inverted. The sop/eop markers stay aligned with their pixels.
- Reset mid-stream: assert reset with 2 beats in flight -> out_valid=0 and frame_active=0 immediately. After release, the first new sop frame is processed with the newly latched cfg.

Source files
------------

// File: rtl/video_effects_stream.sv
// video_effects_stream: two-stage pixel-effects pipeline for the video path.
// Stage 1 applies delete / substitute / quantise, stage 2 applies grayscale /
// negative. Effect selection and colour operands are captured at each
// accepted start-of-packet beat, and every stage carries the enable bits
// that apply to its pixel, so a frame never mixes settings.
//
// Handshake: a beat transfers on a port in any cycle where valid && ready
// are both high at the rising edge. A source holding valid keeps its data,
// sop and eop stable until the transfer. in_ready depends combinationally
// on out_ready only; all other outputs come straight from registers.
module video_effects_stream #(
  parameter int R_BITS     = 5,
  parameter int G_BITS     = 6,
  parameter int B_BITS     = 5,
  parameter int QUANT_DROP = 2,
  localparam int PW        = R_BITS + G_BITS + B_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    effect,
  input  logic [PW-1:0] effect_delete_mask,
  input  logic [PW-1:0] effect_key_color,
  input  logic [PW-1:0] effect_substitute_color,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic          in_eop,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sop,
  output logic          out_eop,
  output logic          frame_active
);

  // Keeps the upper (W - QUANT_DROP) bits of each channel.
  localparam logic [PW-1:0] QMASK = {
    {(R_BITS-QUANT_DROP){1'b1}}, {QUANT_DROP{1'b0}},
    {(G_BITS-QUANT_DROP){1'b1}}, {QUANT_DROP{1'b0}},
    {(B_BITS-QUANT_DROP){1'b1}}, {QUANT_DROP{1'b0}}
  };

  // Widens a W-bit channel to 8 bits by replicating its MSBs into the LSBs.
  function automatic logic [7:0] expand8(input logic [7:0] c, input int w);
    logic [15:0] cx;
    cx = {8'd0, c};
    return 8'((cx << (8 - w)) | (cx >> (2 * w - 8)));
  endfunction

  // Per-frame configuration captured at the sop beat.
  logic [4:0]    cfg_effect;
  logic [PW-1:0] cfg_mask;
  logic [PW-1:0] cfg_key;
  logic [PW-1:0] cfg_subst;

  // Stage 1 holding register.
  logic          s1_valid;
  logic [PW-1:0] s1_data;
  logic          s1_sop;
  logic          s1_eop;
  logic          s1_gray;
  logic          s1_neg;

  logic          s1_ready;
  logic          s2_ready;
  logic          in_fire;
  logic          out_fire;

  // Stage-1 combinational operands and results.
  logic [4:0]    cur_effect;
  logic [PW-1:0] cur_mask;
  logic [PW-1:0] cur_key;
  logic [PW-1:0] cur_subst;
  logic [PW-1:0] p_del;
  logic [PW-1:0] p_sub;
  logic [PW-1:0] p_q;

  // Stage-2 combinational results.
  logic [R_BITS-1:0] ch_r;
  logic [G_BITS-1:0] ch_g;
  logic [B_BITS-1:0] ch_b;
  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [15:0]       luma_acc;
  logic [7:0]        luma;
  logic [PW-1:0]     p_gray;
  logic [PW-1:0]     p_neg;

  // A stage accepts when empty or when its content leaves this cycle.
  always_comb begin
    s2_ready = !out_valid || out_ready;
    s1_ready = !s1_valid || s2_ready;
    in_ready = s1_ready;
    in_fire  = in_valid && s1_ready;
    out_fire = out_valid && out_ready;
  end

  // Stage 1: the sop beat already uses the settings it brings with it.
  always_comb begin
    cur_effect = in_sop ? effect                  : cfg_effect;
    cur_mask   = in_sop ? effect_delete_mask      : cfg_mask;
    cur_key    = in_sop ? effect_key_color        : cfg_key;
    cur_subst  = in_sop ? effect_substitute_color : cfg_subst;
    p_del = cur_effect[0] ? (in_data & ~cur_mask) : in_data;
    p_sub = (cur_effect[1] && (p_del == cur_key)) ? cur_subst : p_del;
    p_q   = cur_effect[2] ? (p_sub & QMASK) : p_sub;
  end

  // Stage 2: BT.601-style luma on 8-bit expanded channels, then optional invert.
  always_comb begin
    ch_r     = s1_data[PW-1 -: R_BITS];
    ch_g     = s1_data[B_BITS +: G_BITS];
    ch_b     = s1_data[B_BITS-1:0];
    r8       = expand8(8'(ch_r), R_BITS);
    g8       = expand8(8'(ch_g), G_BITS);
    b8       = expand8(8'(ch_b), B_BITS);
    luma_acc = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    luma     = luma_acc[15:8];
    p_gray   = s1_gray ? {luma[7 -: R_BITS], luma[7 -: G_BITS], luma[7 -: B_BITS]}
                       : s1_data;
    p_neg    = s1_neg ? ~p_gray : p_gray;
  end

  // Capture the frame configuration on every accepted sop beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_effect <= '0;
      cfg_mask   <= '0;
      cfg_key    <= '0;
      cfg_subst  <= '0;
    end else if (in_fire && in_sop) begin
      cfg_effect <= effect;
      cfg_mask   <= effect_delete_mask;
      cfg_key    <= effect_key_color;
      cfg_subst  <= effect_substitute_color;
    end
  end

  // Stage 1 register: loads the processed input beat with its stage-2 enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_gray  <= 1'b0;
      s1_neg   <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= p_q;
        s1_sop  <= in_sop;
        s1_eop  <= in_eop;
        s1_gray <= cur_effect[3];
        s1_neg  <= cur_effect[4];
      end
    end
  end

  // Stage 2 register: drives the output port and holds it during stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= p_neg;
        out_sop  <= s1_sop;
        out_eop  <= s1_eop;
      end
    end
  end

  // Output-side frame tracking; a single-beat frame never raises the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_active <= 1'b0;
    end else if (out_fire) begin
      if (out_eop)      frame_active <= 1'b0;
      else if (out_sop) frame_active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_video_effects_stream.sv
// tb_video_effects_stream: directed checks of the video effects pipeline with
// hand-computed pixels for the default 5/6/5 format and QUANT_DROP = 2.
module tb_video_effects_stream;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    effect;
  logic [PW-1:0] effect_delete_mask;
  logic [PW-1:0] effect_key_color;
  logic [PW-1:0] effect_substitute_color;
  logic [PW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_sop;
  logic          in_eop;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic          frame_active;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Stimulus queues (one entry per beat) and scoreboard.
  logic [PW-1:0] st_data[$];
  logic [4:0]    st_eff[$];
  logic          st_sop[$];
  logic          st_eop[$];
  logic [PW-1:0] exp_q[$];
  logic          exp_sop_q[$];
  logic          exp_eop_q[$];
  int            acc_q[$];

  // Per-cycle handshake results and the bench's occupancy / frame model.
  logic          in_fire;
  logic          out_fire;
  logic [PW-1:0] e_data;
  logic          e_sop;
  logic          e_eop;
  logic          e_ok;
  int            e_acc;
  int            held;
  logic          exp_fa;
  int            rdy_low_pct;
  logic          hold_low;

  // Clock generation
  always #5 clk = ~clk;

  video_effects_stream dut (
    .clk                     (clk),
    .reset                   (reset),
    .effect                  (effect),
    .effect_delete_mask      (effect_delete_mask),
    .effect_key_color        (effect_key_color),
    .effect_substitute_color (effect_substitute_color),
    .in_data                 (in_data),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_sop                  (in_sop),
    .in_eop                  (in_eop),
    .out_data                (out_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_sop                 (out_sop),
    .out_eop                 (out_eop),
    .frame_active            (frame_active)
  );

  task automatic push_beat(input logic [PW-1:0] d, input logic s, input logic e,
                           input logic [4:0] eff, input logic [PW-1:0] x);
    st_data.push_back(d);
    st_sop.push_back(s);
    st_eop.push_back(e);
    st_eff.push_back(eff);
    exp_q.push_back(x);
    exp_sop_q.push_back(s);
    exp_eop_q.push_back(e);
  endtask

  task automatic clear_queues();
    st_data.delete(); st_sop.delete(); st_eop.delete(); st_eff.delete();
    exp_q.delete(); exp_sop_q.delete(); exp_eop_q.delete(); acc_q.delete();
  endtask

  // Driver: apply last edge's transfers to the model, present the next beat at
  // the falling edge, then resolve both handshakes before the rising edge.
  task automatic drive_cycle();
    @(negedge clk);
    cyc++;
    if (in_fire) held++;
    if (out_fire) begin
      held--;
      if (e_eop)      exp_fa = 1'b0;
      else if (e_sop) exp_fa = 1'b1;
    end
    if (st_data.size() > 0) begin
      in_valid = 1'b1;
      in_data  = st_data[0];
      in_sop   = st_sop[0];
      in_eop   = st_eop[0];
      effect   = st_eff[0];
    end else begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
    end
    out_ready = hold_low ? 1'b0 : (int'($urandom_range(99)) >= rdy_low_pct);
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (in_fire) begin
      void'(st_data.pop_front()); void'(st_sop.pop_front());
      void'(st_eop.pop_front());  void'(st_eff.pop_front());
      acc_q.push_back(cyc);
    end
    e_ok = 1'b0;
    if (out_fire && exp_q.size() > 0) begin
      e_data = exp_q.pop_front();
      e_sop  = exp_sop_q.pop_front();
      e_eop  = exp_eop_q.pop_front();
      e_acc  = acc_q.pop_front();
      e_ok   = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset out_data: got %h want 0000", out_data); end
    checks++; if ({out_sop, out_eop} !== 2'b00) begin errors++; $display("FAIL reset markers: got %b want 00", {out_sop, out_eop}); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset frame_active: got %b want 0", frame_active); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post-reset idle out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    push_beat(16'h1234, 1'b1, 1'b0, 5'b00000, 16'h1234);
    push_beat(16'hF800, 1'b0, 1'b0, 5'b00000, 16'hF800);
    push_beat(16'h07E0, 1'b0, 1'b1, 5'b00000, 16'h07E0);
    for (int i = 0; i < 50 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL bypass beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
        checks++;
        if (cyc - e_acc !== 2) begin errors++; $display("FAIL bypass latency: got %0d want 2", cyc - e_acc); end
      end
    end
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL bypass timeout: %0d beats outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_negative_grayscale();
    push_beat(16'hF800, 1'b1, 1'b1, 5'b10000, 16'h07FF);
    push_beat(16'hF800, 1'b1, 1'b0, 5'b01000, 16'h4A69);
    push_beat(16'hFFFF, 1'b0, 1'b1, 5'b01000, 16'hFFFF);
    for (int i = 0; i < 50 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL neg/gray beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
        // The single-beat negative frame must leave frame_active low.
        if (e_sop && e_eop) begin
          drive_cycle();
          checks++;
          if (frame_active !== 1'b0) begin errors++; $display("FAIL single-beat frame_active: got %b want 0", frame_active); end
        end
      end
    end
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL neg/gray timeout: %0d beats outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_chain();
    effect_delete_mask      = 16'h001F;
    effect_key_color        = 16'hF800;
    effect_substitute_color = 16'h0000;
    push_beat(16'hF81F, 1'b1, 1'b0, 5'b00111, 16'h0000);
    push_beat(16'hFFFF, 1'b0, 1'b1, 5'b00111, 16'hE780);
    // Second frame: new key/subst latched with its sop; one hit, one miss.
    for (int i = 0; i < 50 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      if (st_data.size() == 0 && exp_q.size() == 2 && !out_fire) begin
        effect_key_color        = 16'h1234;
        effect_substitute_color = 16'hABCD;
        push_beat(16'h1234, 1'b1, 1'b0, 5'b00010, 16'hABCD);
        push_beat(16'h1235, 1'b0, 1'b1, 5'b00010, 16'h1235);
      end
      checks++;
      if (frame_active !== exp_fa) begin errors++; $display("FAIL chain frame_active: got %b want %b", frame_active, exp_fa); end
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL chain beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
      end
    end
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL chain timeout: %0d beats outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_frame_latch();
    effect_delete_mask = 16'h0000;
    // Frame A starts in bypass; the effect port flips to negative mid-frame.
    push_beat(16'h1234, 1'b1, 1'b0, 5'b00000, 16'h1234);
    push_beat(16'h5678, 1'b0, 1'b0, 5'b00000, 16'h5678);
    push_beat(16'h9ABC, 1'b0, 1'b0, 5'b10000, 16'h9ABC);
    push_beat(16'hDEF0, 1'b0, 1'b1, 5'b10000, 16'hDEF0);
    // Frame B follows back to back and latches negative at its sop.
    push_beat(16'h1234, 1'b1, 1'b0, 5'b10000, 16'hEDCB);
    push_beat(16'h00FF, 1'b0, 1'b1, 5'b10000, 16'hFF00);
    for (int i = 0; i < 60 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      checks++;
      if (frame_active !== exp_fa) begin errors++; $display("FAIL latch frame_active: got %b want %b", frame_active, exp_fa); end
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL latch beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
      end
    end
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL latch timeout: %0d beats outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic          stall_pend;
    logic [PW-1:0] stall_d;
    logic          exp_rdy;
    logic [PW-1:0] px;
    stall_pend = 1'b0;
    stall_d    = '0;
    // Quantise then negate: 5/6/5 with two LSBs dropped keeps mask E79C.
    for (int i = 0; i < 1000; i++) begin
      px = 16'(i * 40503 + 7);
      push_beat(px, i == 0, i == 999, 5'b10100, ~(px & 16'hE79C));
    end
    rdy_low_pct = 30;
    for (int i = 0; i < 5000 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      exp_rdy = !(held == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp in_ready: got %b want %b (held=%0d)", in_ready, exp_rdy, held); end
      if (stall_pend) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== stall_d) begin
          errors++;
          $display("FAIL bp stall hold: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, stall_d);
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_d    = out_data;
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL bp beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
      end
    end
    rdy_low_pct = 0;
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL bp timeout: %0d beats outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_stream();
    // Open a frame so frame_active is high.
    push_beat(16'h1111, 1'b1, 1'b0, 5'b00000, 16'h1111);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive_cycle();
    drive_cycle();
    checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL midrst frame open: got %b want 1", frame_active); end
    // Fill both stages with the output stalled.
    hold_low = 1'b1;
    push_beat(16'h2222, 1'b0, 1'b0, 5'b00000, 16'h2222);
    push_beat(16'h3333, 1'b0, 1'b1, 5'b00000, 16'h3333);
    for (int i = 0; i < 20 && st_data.size() > 0; i++) drive_cycle();
    drive_cycle();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL midrst full: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid); end
    #1 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL midrst frame_active: got %b want 0", frame_active); end
    clear_queues();
    in_fire = 1'b0; out_fire = 1'b0; held = 0; exp_fa = 1'b0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    hold_low = 1'b0;
    // New frame latches grayscale; no stale beat may come out first.
    push_beat(16'hF800, 1'b1, 1'b0, 5'b01000, 16'h4A69);
    push_beat(16'hFFFF, 1'b0, 1'b1, 5'b01000, 16'hFFFF);
    for (int i = 0; i < 50 && (st_data.size() > 0 || exp_q.size() > 0); i++) begin
      drive_cycle();
      if (out_fire) begin
        checks++;
        if (!e_ok || out_data !== e_data || out_sop !== e_sop || out_eop !== e_eop) begin
          errors++;
          $display("FAIL midrst beat: got %h sop=%b eop=%b want %h sop=%b eop=%b", out_data, out_sop, out_eop, e_data, e_sop, e_eop);
        end
      end
    end
    checks++; if (st_data.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL midrst timeout: %0d beats outstanding want 0", exp_q.size()); end
    repeat (3) drive_cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst trailing beat: got out_valid=%b want 0", out_valid); end
  endtask

  // Main sequence
  initial begin
    reset                   = 1'b0;
    effect                  = 5'b0;
    effect_delete_mask      = '0;
    effect_key_color        = '0;
    effect_substitute_color = '0;
    in_data                 = '0;
    in_valid                = 1'b0;
    in_sop                  = 1'b0;
    in_eop                  = 1'b0;
    out_ready               = 1'b0;
    in_fire                 = 1'b0;
    out_fire                = 1'b0;
    e_data                  = '0;
    e_sop                   = 1'b0;
    e_eop                   = 1'b0;
    e_ok                    = 1'b0;
    e_acc                   = 0;
    held                    = 0;
    exp_fa                  = 1'b0;
    rdy_low_pct             = 0;
    hold_low                = 1'b0;
    test_reset();
    test_bypass();
    test_negative_grayscale();
    test_chain();
    test_frame_latch();
    test_backpressure();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
